// File: rtl/lapido_pkg.sv
// Shared types and default sizing for the instruction phase sequencer.
package lapido_pkg;

    typedef enum logic [1:0] {
        StRun,
        StMemWait,
        StHalted
    } seq_state_e;

    localparam int unsigned DefaultNPhases  = 5;
    localparam int unsigned DefaultMemPhase = 3;

endpackage

// File: rtl/phase_decoder.sv
// One-hot decode of a binary phase index.
module phase_decoder #(
    parameter int unsigned N_PHASES = 5,
    localparam int unsigned PH_W    = $clog2(N_PHASES)
) (
    input  logic [PH_W-1:0]     phase,
    output logic [N_PHASES-1:0] onehot
);

    always_comb begin
        onehot = '0;
        for (int i = 0; i < N_PHASES; i++) begin
            onehot[i] = (phase == PH_W'(i));
        end
    end

endmodule

// File: rtl/phase_sequencer.sv
// Multi-cycle instruction phase sequencer with memory stall and halt handling.
// Define PHASE_SEQ_RETIRE_CNT_EN to build the 32-bit retired-instruction counter.
module phase_sequencer
    import lapido_pkg::*;
#(
    parameter int unsigned N_PHASES  = DefaultNPhases,
    parameter int unsigned MEM_PHASE = DefaultMemPhase,
    localparam int unsigned PH_W     = $clog2(N_PHASES)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                halt,
    input  logic                mem_ready,
    output logic [PH_W-1:0]     phase,
    output logic [N_PHASES-1:0] phase_onehot,
    output logic                if_enable,
    output logic                pc_write,
    output logic                stalled,
    output logic                halted,
    output logic [31:0]         retired_count
);

    if (N_PHASES < 2 || N_PHASES > 16 || MEM_PHASE >= N_PHASES) begin : g_bad_params
        $error("phase_sequencer: N_PHASES must be 2..16 and MEM_PHASE < N_PHASES");
    end

    localparam logic [PH_W-1:0] MemPh  = PH_W'(MEM_PHASE);
    localparam logic [PH_W-1:0] LastPh = PH_W'(N_PHASES - 1);

    seq_state_e            state_q;
    logic [PH_W-1:0]       phase_q;
    logic [N_PHASES-1:0]   dec_onehot;
    logic                  active;

    assign active    = (state_q != StHalted);
    assign stalled   = active && (phase_q == MemPh) && !mem_ready;
    assign if_enable = active && (phase_q == '0);
    assign pc_write  = active && (phase_q == LastPh) && !stalled;
    assign halted    = (state_q == StHalted);
    assign phase     = phase_q;

    // RUN and MEM_WAIT share one advance path; only the stall decides which state holds.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StRun;
            phase_q <= '0;
        end else begin
            unique case (state_q)
                StRun, StMemWait: begin
                    if (stalled) begin
                        state_q <= StMemWait;
                    end else if (phase_q == LastPh) begin
                        phase_q <= '0;
                        state_q <= halt ? StHalted : StRun;
                    end else begin
                        phase_q <= phase_q + 1'b1;
                        state_q <= StRun;
                    end
                end
                StHalted: begin
                    phase_q <= '0;
                    if (!halt) state_q <= StRun;
                end
                default: begin
                    state_q <= StRun;
                    phase_q <= '0;
                end
            endcase
        end
    end

    phase_decoder #(
        .N_PHASES (N_PHASES)
    ) u_phase_decoder (
        .phase  (phase_q),
        .onehot (dec_onehot)
    );

    assign phase_onehot = halted ? '0 : dec_onehot;

`ifdef PHASE_SEQ_RETIRE_CNT_EN
    logic [31:0] retired_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            retired_q <= '0;
        end else if (pc_write) begin
            retired_q <= retired_q + 32'd1;
        end
    end

    assign retired_count = retired_q;
`else
    assign retired_count = '0;
`endif

endmodule

// File: tb/tb_phase_sequencer.sv
// Directed self-checking bench for phase_sequencer at N_PHASES=5, MEM_PHASE=3.
module tb_phase_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        halt;
    logic        mem_ready;
    logic [2:0]  phase;
    logic [4:0]  phase_onehot;
    logic        if_enable;
    logic        pc_write;
    logic        stalled;
    logic        halted;
    logic [31:0] retired_count;

    int total = 0;
    int bad   = 0;

`ifdef PHASE_SEQ_RETIRE_CNT_EN
    localparam bit CntEn = 1'b1;
`else
    localparam bit CntEn = 1'b0;
`endif

    always #5 clk = ~clk;

    phase_sequencer #(
        .N_PHASES  (5),
        .MEM_PHASE (3)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .halt          (halt),
        .mem_ready     (mem_ready),
        .phase         (phase),
        .phase_onehot  (phase_onehot),
        .if_enable     (if_enable),
        .pc_write      (pc_write),
        .stalled       (stalled),
        .halted        (halted),
        .retired_count (retired_count)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_run(input string tag, input int ph, input bit ife, input bit pcw,
                             input bit stl);
        #1;
        check({tag, "_phase"}, 32'(phase), 32'(ph));
        check({tag, "_ife"},   32'(if_enable), 32'(ife));
        check({tag, "_pcw"},   32'(pc_write), 32'(pcw));
        check({tag, "_stl"},   32'(stalled), 32'(stl));
        check({tag, "_hlt"},   32'(halted), 32'd0);
    endtask

    initial begin
        rst = 1'b1; halt = 1'b0; mem_ready = 1'b1;
        tick();
        rst = 1'b0;

        // Reset state
        check_run("reset", 0, 1'b1, 1'b0, 1'b0);
        check("reset_onehot", 32'(phase_onehot), 32'h01);
        check("reset_cnt", retired_count, 32'd0);

        // Free run: 15 cycles
        for (int k = 0; k < 15; k++) begin
            check_run("free", k % 5, (k % 5) == 0, (k % 5) == 4, 1'b0);
            check("free_onehot", 32'(phase_onehot), 32'(1) << (k % 5));
            tick();
        end
        check("free_cnt", retired_count, CntEn ? 32'd3 : 32'd0);

        // Memory stall at phase 3; mem_ready low elsewhere must not matter
        mem_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check_run("pre_stall", k, k == 0, 1'b0, 1'b0);
            tick();
        end
        for (int k = 0; k < 3; k++) begin
            check_run("stall", 3, 1'b0, 1'b0, 1'b1);
            tick();
        end
        mem_ready = 1'b1;
        check_run("stall_rel", 3, 1'b0, 1'b0, 1'b0);
        tick();
        mem_ready = 1'b0;
        check_run("post_stall", 4, 1'b0, 1'b1, 1'b0);
        tick();
        mem_ready = 1'b1;
        check("stall_cnt", retired_count, CntEn ? 32'd4 : 32'd0);

        // Halt raised at phase 1: instruction completes, then park
        check_run("h0", 0, 1'b1, 1'b0, 1'b0);
        tick();
        halt = 1'b1;
        check_run("h1", 1, 1'b0, 1'b0, 1'b0);
        tick();
        check_run("h2", 2, 1'b0, 1'b0, 1'b0);
        tick();
        check_run("h3", 3, 1'b0, 1'b0, 1'b0);
        tick();
        check_run("h4", 4, 1'b0, 1'b1, 1'b0);
        tick();
        for (int k = 0; k < 2; k++) begin
            #1;
            check("halt_hlt",    32'(halted), 32'd1);
            check("halt_onehot", 32'(phase_onehot), 32'd0);
            check("halt_phase",  32'(phase), 32'd0);
            check("halt_ife",    32'(if_enable), 32'd0);
            check("halt_pcw",    32'(pc_write), 32'd0);
            tick();
        end
        halt = 1'b0;
        #1;
        check("unhalt_still", 32'(halted), 32'd1);
        tick();
        check_run("resume", 0, 1'b1, 1'b0, 1'b0);
        check("resume_onehot", 32'(phase_onehot), 32'h01);

        // Reset in the middle of a stall
        tick(); tick(); tick();
        mem_ready = 1'b0;
        tick();
        check_run("ms_wait", 3, 1'b0, 1'b0, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0; mem_ready = 1'b1;
        check_run("ms_reset", 0, 1'b1, 1'b0, 1'b0);
        check("ms_cnt", retired_count, 32'd0);

        // Reset while parked in HALTED with halt still high
        halt = 1'b1;
        for (int k = 0; k < 5; k++) tick();
        #1;
        check("mh_hlt", 32'(halted), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_run("mh_reset", 0, 1'b1, 1'b0, 1'b0);
        halt = 1'b0;
        tick();
        check_run("mh_run", 1, 1'b0, 1'b0, 1'b0);

        // Retire counter wrap
        for (int k = 0; k < 4; k++) tick();
        check_run("wrap_p0", 0, 1'b1, 1'b0, 1'b0);
`ifdef PHASE_SEQ_RETIRE_CNT_EN
        force dut.retired_q = 32'hFFFF_FFFE;
        #1;
        release dut.retired_q;
`endif
        for (int k = 0; k < 5; k++) tick();
        check("wrap_max", retired_count, CntEn ? 32'hFFFF_FFFF : 32'd0);
        for (int k = 0; k < 5; k++) tick();
        check("wrap_zero", retired_count, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
